// File: rtl/egress_slot_arbiter.sv
// Round-robin arbiter that admits one que-slot handler at a time and forwards its frame words to the egress FIFO.
// Optional EGRESS_ARB_FRAME_COUNT_EN adds per-frame word count, frame_done and frame_overlength outputs.
module egress_slot_arbiter #(
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_FRAME_WORDS = 1518,
  parameter int START_TIMEOUT   = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_SLOTS-1:0]         slot_ready,
  input  logic [9*NUM_SLOTS-1:0]       slot_push_data,
  input  logic [NUM_SLOTS-1:0]         slot_push_data_valid,
  input  logic [NUM_SLOTS-1:0]         slot_push_data_ready,
  input  logic [11:0]                  egress_free,
  output logic [NUM_SLOTS-1:0]         slot_enable,
  output logic [8:0]                   egress_data,
  output logic                         egress_valid,
  output logic                         busy,
  output logic [$clog2(NUM_SLOTS)-1:0] grant_index,
  output logic                         start_timeout,
  output logic                         sof_error
`ifdef EGRESS_ARB_FRAME_COUNT_EN
  ,
  output logic [11:0]                  frame_words,
  output logic                         frame_done,
  output logic                         frame_overlength
`endif
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [11:0]          MAX_WORDS = 12'(MAX_FRAME_WORDS);
  localparam logic [TW-1:0]        TMO       = TW'(START_TIMEOUT);
  localparam logic [NUM_SLOTS-1:0] ONE_HOT0  = NUM_SLOTS'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_STREAM, S_RELEASE} state_t;

  state_t               state_q;
  logic [IW-1:0]        last_q, grant_q;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic                 first_q;
  logic [NUM_SLOTS-1:0] enable_q;
  logic [8:0]           egress_data_q;
  logic                 egress_valid_q, start_timeout_q, sof_error_q;

  logic [8:0]    slot_word [NUM_SLOTS];
  logic [IW-1:0] pick_d;
  logic          pick_valid_d;
  logic          sel_valid, sel_push_ready, sel_slot_ready;
  logic [8:0]    sel_data;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) slot_word[i] = slot_push_data[9*i +: 9];
  end

  // Walk offsets from farthest to nearest so the slot closest after last_q wins.
  always_comb begin
    int            sum;
    logic [IW-1:0] cand;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sum          = 0;
    cand         = '0;
    pick_d       = '0;
    pick_valid_d = 1'b0;
    for (int off = NUM_SLOTS; off >= 1; off--) begin
      sum = int'(last_q) + off;
      if (sum >= NUM_SLOTS) sum = sum - NUM_SLOTS;
      cand = IW'(sum);
      if (slot_ready[cand]) begin
        pick_d       = cand;
        pick_valid_d = 1'b1;
      end
    end
  end

  assign sel_valid      = slot_push_data_valid[grant_q];
  assign sel_push_ready = slot_push_data_ready[grant_q];
  assign sel_slot_ready = slot_ready[grant_q];
  assign sel_data       = slot_word[grant_q];
  assign cnt_d          = cnt_q + TW'(1);

`ifdef EGRESS_ARB_FRAME_COUNT_EN
  logic [11:0] words_q, words_inc, words_final, frame_words_q;
  logic        frame_done_q, frame_overlength_q;

  assign words_inc   = (words_q == 12'hFFF) ? words_q : words_q + 12'd1;
  assign words_final = sel_valid ? words_inc : words_q;
`endif

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state_q         <= S_IDLE;
      last_q          <= IW'(NUM_SLOTS - 1);
      grant_q         <= '0;
      cnt_q           <= '0;
      first_q         <= 1'b0;
      enable_q        <= '0;
      egress_data_q   <= '0;
      egress_valid_q  <= 1'b0;
      start_timeout_q <= 1'b0;
      sof_error_q     <= 1'b0;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
      words_q            <= '0;
      frame_words_q      <= '0;
      frame_done_q       <= 1'b0;
      frame_overlength_q <= 1'b0;
`endif
    end else begin
      enable_q        <= '0;
      egress_valid_q  <= 1'b0;
      start_timeout_q <= 1'b0;
      sof_error_q     <= 1'b0;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
      frame_done_q       <= 1'b0;
      frame_overlength_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          // Admission only when a whole frame is guaranteed to fit; egress is never stalled.
          if (pick_valid_d && (egress_free >= MAX_WORDS)) begin
            enable_q <= ONE_HOT0 << pick_d;
            grant_q  <= pick_d;
            last_q   <= pick_d;
            cnt_q    <= '0;
            first_q  <= 1'b1;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
            words_q  <= '0;
`endif
            state_q  <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (sel_push_ready) begin
            state_q <= S_STREAM;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TMO) begin
              start_timeout_q <= 1'b1;
              state_q         <= S_IDLE;
            end
          end
        end
        S_STREAM: begin
          if (sel_valid) begin
            egress_valid_q <= 1'b1;
            egress_data_q  <= sel_data;
            first_q        <= 1'b0;
            if (first_q && !sel_data[8]) sof_error_q <= 1'b1;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
            words_q <= words_inc;
`endif
          end
          if (!sel_push_ready) begin
            state_q <= S_RELEASE;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
            frame_done_q       <= 1'b1;
            frame_words_q      <= words_final;
            frame_overlength_q <= (words_final > MAX_WORDS);
`endif
          end
        end
        S_RELEASE: begin
          if (!sel_slot_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign slot_enable   = enable_q;
  assign egress_data   = egress_data_q;
  assign egress_valid  = egress_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_index   = grant_q;
  assign start_timeout = start_timeout_q;
  assign sof_error     = sof_error_q;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
  assign frame_words      = frame_words_q;
  assign frame_done       = frame_done_q;
  assign frame_overlength = frame_overlength_q;
`endif

endmodule

// File: tb/tb_egress_slot_arbiter.sv
// Self-checking bench for egress_slot_arbiter: vector table, directed corner sequences, and randomized frames
// checked against a round-robin/one-cycle-latency reference model. Honors EGRESS_ARB_FRAME_COUNT_EN.
module tb_egress_slot_arbiter;

  localparam int NS  = 4;
  localparam int MAX = 1518;

  logic          clock;
  logic          reset_n;
  logic [NS-1:0] r_ready, r_valid, r_pready;
  logic [9*NS-1:0] r_data;
  logic [11:0]   r_free;
  logic [NS-1:0] slot_enable;
  logic [8:0]    egress_data;
  logic          egress_valid, busy, start_timeout, sof_error;
  logic [1:0]    grant_index;
`ifdef EGRESS_ARB_FRAME_COUNT_EN
  logic [11:0]   frame_words;
  logic          frame_done, frame_overlength;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  egress_slot_arbiter #(.NUM_SLOTS(NS), .MAX_FRAME_WORDS(MAX), .START_TIMEOUT(8)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .slot_ready           (r_ready),
    .slot_push_data       (r_data),
    .slot_push_data_valid (r_valid),
    .slot_push_data_ready (r_pready),
    .egress_free          (r_free),
    .slot_enable          (slot_enable),
    .egress_data          (egress_data),
    .egress_valid         (egress_valid),
    .busy                 (busy),
    .grant_index          (grant_index),
    .start_timeout        (start_timeout),
    .sof_error            (sof_error)
`ifdef EGRESS_ARB_FRAME_COUNT_EN
    ,
    .frame_words          (frame_words),
    .frame_done           (frame_done),
    .frame_overlength     (frame_overlength)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, slot_enable, 0);
    check({tag, "_evalid"}, egress_valid, 0);
    check({tag, "_edata"}, egress_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gidx"}, grant_index, 0);
    check({tag, "_tmo"}, start_timeout, 0);
    check({tag, "_sof"}, sof_error, 0);
`ifdef EGRESS_ARB_FRAME_COUNT_EN
    check({tag, "_fwords"}, frame_words, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_fover"}, frame_overlength, 0);
`endif
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    r_ready  = '0;
    r_valid  = '0;
    r_pready = '0;
    r_data   = '0;
    r_free   = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  // Walk a granted slot through a zero-length frame back to idle.
  task automatic quick_release(input int g);
    r_ready     = '0;
    r_valid     = '0;
    r_pready    = '0;
    r_pready[g] = 1'b1;
    tick();
    r_pready = '0;
    tick();
    tick();
    check("release_idle", busy, 0);
  endtask

  function automatic int rr_pick(input logic [NS-1:0] rdy, input int last);
    for (int off = 1; off <= NS; off++) begin
      int idx;
      idx = (last + off) % NS;
      if (rdy[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    logic [NS-1:0] ready;
    logic [11:0]   free;
    logic [NS-1:0] exp_en;
    int            exp_gi;
  } vec_t;

  vec_t vecs[10];

  // Random-test handler state, one entry per slot.
  int   pend[NS], phase[NS], flen[NS], kw[NS], fw[NS], cool[NS];
  logic late[NS], bad[NS];

  initial begin
    logic [8:0] word;
    logic       exp_v, exp_sof, exp_done;
    logic [8:0] exp_d;
    int         exp_fw, active, mlast, w, total, done_frames, frame_no, tail;

    // Priority after reset starts at slot 0; each grant moves last to the winner.
    vecs[0] = '{4'b1111, 12'd1517, 4'b0000, 0};
    vecs[1] = '{4'b0000, 12'd2000, 4'b0000, 0};
    vecs[2] = '{4'b1010, 12'd1518, 4'b0010, 1};
    vecs[3] = '{4'b1011, 12'd4095, 4'b1000, 3};
    vecs[4] = '{4'b1011, 12'd2000, 4'b0001, 0};
    vecs[5] = '{4'b0001, 12'd2000, 4'b0001, 0};
    vecs[6] = '{4'b1111, 12'd0,    4'b0000, 0};
    vecs[7] = '{4'b1100, 12'd1600, 4'b0100, 2};
    vecs[8] = '{4'b0111, 12'd3000, 4'b0001, 0};
    vecs[9] = '{4'b1111, 12'hFFF,  4'b0010, 1};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      r_ready  = vecs[i].ready;
      r_free   = vecs[i].free;
      r_valid  = '0;
      r_pready = '0;
      tick();
      check($sformatf("vec%0d_enable", i), slot_enable, vecs[i].exp_en);
      check($sformatf("vec%0d_busy", i), busy, (vecs[i].exp_en != 0));
      if (vecs[i].exp_en != 0) begin
        check($sformatf("vec%0d_gidx", i), grant_index, vecs[i].exp_gi);
        quick_release(vecs[i].exp_gi);
      end else begin
        r_ready = '0;
      end
    end

    // Start timeout on slot 1, slot 2 next; slot 2's push_data_ready must be ignored meanwhile.
    do_reset();
    r_ready = 4'b0010;
    r_free  = 12'd2000;
    tick();
    check("tmo_grant", slot_enable, 4'b0010);
    r_ready  = 4'b0110;
    r_pready = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("tmo_pulse_t%0d", t), start_timeout, (t == 8));
      check($sformatf("tmo_busy_t%0d", t), busy, (t != 8));
    end
    tick();
    check("tmo_next_grant", slot_enable, 4'b0100);
    check("tmo_next_gidx", grant_index, 2);
    check("tmo_pulse_once", start_timeout, 0);

    // Overlong frame from slot 2 with a bad first word; slot 1 noise must not leak.
    r_ready  = 4'b0100;
    r_pready = 4'b0100;
    tick();
    for (int k = 0; k < 1600; k++) begin
      word = (k == 0) ? 9'h0AA : {1'b0, 8'(k)};
      r_data[18 +: 9] = word;
      r_data[9 +: 9]  = 9'h155;
      r_valid         = 4'b0110;
      if (k == 1599) r_pready = 4'b0000;
      tick();
      check("long_valid", egress_valid, 1);
      check("long_data", egress_data, word);
      check("long_sof", sof_error, (k == 0));
    end
`ifdef EGRESS_ARB_FRAME_COUNT_EN
    check("long_done", frame_done, 1);
    check("long_words", frame_words, 1600);
    check("long_overlength", frame_overlength, 1);
`endif
    r_valid = '0;
    tick();
    check("long_release_wait", busy, 1);
    check("long_no_extra", egress_valid, 0);
    r_ready = '0;
    tick();
    check("long_idle", busy, 0);

    // Reset in the middle of a frame from slot 0.
    r_ready = 4'b0001;
    tick();
    check("mid_grant", slot_enable, 4'b0001);
    r_pready = 4'b0001;
    tick();
    for (int k = 0; k <= 20; k++) begin
      r_data[0 +: 9] = {(k == 0), 8'(k)};
      r_valid        = 4'b0001;
      if (k == 20) reset_n = 1'b0;
      tick();
    end
    check_all_zero("midrst");
    reset_n  = 1'b1;
    r_valid  = '0;
    r_pready = '0;
    r_ready  = 4'b1111;
    tick();
    check("midrst_first_grant", slot_enable, 4'b0001);
    check("midrst_first_gidx", grant_index, 0);
    quick_release(0);

    // Randomized frames against the reference model.
    do_reset();
    total = 0;
    for (int i = 0; i < NS; i++) begin
      pend[i]  = $urandom_range(3, 6);
      total   += pend[i];
      phase[i] = 0;
      cool[i]  = 0;
    end
    r_ready     = '1;
    r_free      = 12'd2000;
    active      = -1;
    mlast       = NS - 1;
    exp_v       = 1'b0;
    exp_sof     = 1'b0;
    exp_done    = 1'b0;
    exp_d       = '0;
    exp_fw      = 0;
    done_frames = 0;
    frame_no    = 0;
    tail        = 0;
    for (int cyc = 0; cyc < 20000 && tail < 6; cyc++) begin
      tick();
      check("rnd_valid", egress_valid, exp_v);
      if (exp_v) check("rnd_data", egress_data, exp_d);
      check("rnd_sof", sof_error, exp_sof);
      check("rnd_tmo", start_timeout, 0);
`ifdef EGRESS_ARB_FRAME_COUNT_EN
      check("rnd_fdone", frame_done, exp_done);
      if (exp_done) begin
        check("rnd_fwords", frame_words, exp_fw);
        check("rnd_fover", frame_overlength, 0);
      end
`endif
      if (slot_enable !== '0) begin
        w = rr_pick(r_ready, mlast);
        check("rnd_grant_slot", slot_enable, (w >= 0) ? (32'd1 << w) : 32'd0);
        check("rnd_grant_legal", {(active == -1), (r_free >= 12'(MAX))}, 2'b11);
        if (w >= 0) begin
          check("rnd_grant_gidx", grant_index, w);
          mlast    = w;
          active   = w;
          phase[w] = 1;
          pend[w]--;
          flen[w]  = $urandom_range(1, 40);
          kw[w]    = 0;
          fw[w]    = 0;
          late[w]  = 1'($urandom_range(0, 1));
          bad[w]   = ((frame_no % 4) == 1);
          frame_no++;
        end
      end
      exp_v    = 1'b0;
      exp_sof  = 1'b0;
      exp_done = 1'b0;
      for (int i = 0; i < NS; i++) begin
        case (phase[i])
          0: begin
            r_ready[i]      = (pend[i] > 0);
            r_valid[i]      = 1'($urandom);
            r_pready[i]     = 1'($urandom);
            r_data[9*i +: 9] = 9'($urandom);
          end
          1: begin
            r_valid[i]  = 1'b0;
            r_pready[i] = 1'b1;
            phase[i]    = 2;
          end
          2: begin
            if (kw[i] < flen[i]) begin
              if ($urandom_range(0, 3) != 0) begin
                word    = 9'($urandom);
                word[8] = (kw[i] == 0) && !bad[i];
                r_data[9*i +: 9] = word;
                r_valid[i] = 1'b1;
                exp_v   = 1'b1;
                exp_d   = word;
                exp_sof = (kw[i] == 0) && bad[i];
                kw[i]++;
                fw[i]++;
                if (kw[i] == flen[i] && !late[i]) begin
                  r_pready[i] = 1'b0;
                  exp_done    = 1'b1;
                  exp_fw      = fw[i];
                  phase[i]    = 3;
                  cool[i]     = 3;
                  done_frames++;
                end
              end else begin
                r_valid[i] = 1'b0;
              end
            end else begin
              r_valid[i]  = 1'b0;
              r_pready[i] = 1'b0;
              exp_done    = 1'b1;
              exp_fw      = fw[i];
              phase[i]    = 3;
              cool[i]     = 3;
              done_frames++;
            end
          end
          default: begin
            r_valid[i]  = 1'b0;
            r_pready[i] = 1'b0;
            cool[i]--;
            r_ready[i]  = (cool[i] == 0) && (pend[i] > 0);
            if (cool[i] == 1) active = -1;
            if (cool[i] == 0) phase[i] = 0;
          end
        endcase
      end
      if ($urandom_range(0, 9) == 0) r_free = 12'($urandom_range(0, MAX - 1));
      else                           r_free = 12'($urandom_range(MAX, 4095));
      if (done_frames == total) tail++;
    end
    check("rnd_frames_done", done_frames, total);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
